// File: rtl/mnist_img_loader.sv
// Streams one frame of pixel bytes into the flattened image vector for mnist_top,
// runs one inference and hands the predicted digit back over a valid/ready port.
module mnist_img_loader #(
    parameter int NPIX    = 784,
    parameter int PIXW    = 8,
    parameter int TIMEOUT = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [PIXW-1:0]      s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [NPIX*PIXW-1:0] img_data,
    output logic                 acc_start,
    input  logic                 acc_done,
    input  logic [3:0]           acc_pred,
    output logic                 res_valid,
    output logic [3:0]           res_digit,
    output logic                 res_err,
    input  logic                 res_ready,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [9:0]    LAST_IDX = 10'(NPIX - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_LOAD, S_DROP, S_START, S_WAIT, S_CAPT, S_RESULT} state_t;

    state_t        state;
    logic [9:0]    pix_idx;
    logic [TW-1:0] tmo_cnt;
    logic          done_q;
    logic          hs;

    assign hs = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOAD;
            pix_idx   <= '0;
            tmo_cnt   <= '0;
            done_q    <= 1'b0;
            img_data  <= '0;
            s_ready   <= 1'b0;
            acc_start <= 1'b0;
            res_valid <= 1'b0;
            res_digit <= 4'h0;
            res_err   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 16'd0;
            busy      <= 1'b0;
        end else begin
            acc_start <= 1'b0;
            frame_err <= 1'b0;
            // done_q follows acc_done continuously, so a done level left over from the
            // previous frame is already in done_q at WAIT entry and never reads as a rise.
            done_q    <= acc_done;
            case (state)
                S_LOAD: begin
                    s_ready <= 1'b1;
                    if (hs) begin
                        img_data[int'(pix_idx)*PIXW +: PIXW] <= s_data;
                        if (pix_idx == LAST_IDX) begin
                            pix_idx <= '0;
                            busy    <= 1'b1;
                            if (s_last) begin
                                state     <= S_START;
                                acc_start <= 1'b1;
                                s_ready   <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_DROP;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            pix_idx   <= '0;
                        end else begin
                            pix_idx <= pix_idx + 10'd1;
                        end
                    end
                end
                S_DROP: begin
                    if (hs && s_last) begin
                        state <= S_LOAD;
                        busy  <= 1'b0;
                    end
                end
                S_START: begin
                    pix_idx <= '0;
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (acc_done && !done_q) begin
                        state <= S_CAPT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_digit <= 4'hF;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_RESULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                // pred_digit settles one cycle after done rises, so sample it here.
                S_CAPT: begin
                    res_digit <= acc_pred;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        s_ready   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_img_loader.sv
// Randomized bench for mnist_img_loader with a stub accelerator and an outcome model
// derived from frame lengths, chosen predictions and the documented cycle timing.
module tb_mnist_img_loader;
    localparam int NPIX = 784;
    localparam int PIXW = 8;
    localparam int TMO  = 50;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 s_valid = 1'b0;
    logic [PIXW-1:0]      s_data = '0;
    logic                 s_last = 1'b0;
    logic                 s_ready;
    logic [NPIX*PIXW-1:0] img_data;
    logic                 acc_start;
    logic                 acc_done = 1'b0;
    logic [3:0]           acc_pred = 4'h0;
    logic                 res_valid;
    logic [3:0]           res_digit;
    logic                 res_err;
    logic                 res_ready = 1'b0;
    logic                 frame_err;
    logic [15:0]          frame_cnt;
    logic                 busy;

    mnist_img_loader #(.NPIX(NPIX), .PIXW(PIXW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .img_data(img_data), .acc_start(acc_start),
        .acc_done(acc_done), .acc_pred(acc_pred), .res_valid(res_valid),
        .res_digit(res_digit), .res_err(res_err), .res_ready(res_ready),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int                   n_chk = 0;
    int                   n_fail = 0;
    int                   start_seen = 0;
    int                   ferr_seen = 0;
    int                   err_at;
    logic [15:0]          exp_cnt = 16'd0;
    logic [NPIX*PIXW-1:0] exp_vec = '0;

    always @(negedge clk) begin
        if (acc_start) start_seen++;
        if (frame_err) ferr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n random bytes with s_last on byte last_pos; records where frame_err showed.
    task automatic send_bytes(input int n, input int last_pos);
        logic ready_ok = 1'b1;
        err_at = -1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = PIXW'($urandom);
            s_last  = (i == last_pos);
            if (i < NPIX) exp_vec[i*PIXW +: PIXW] = s_data;
            if (!s_ready) ready_ok = 1'b0;
            tick();
            if (frame_err && err_at < 0) err_at = i;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("s_ready_stream", ready_ok, 1);
    endtask

    task automatic bad_frame(input int n, input int last_pos);
        int s0 = start_seen;
        int f0 = ferr_seen;
        int exp_pos = (last_pos < NPIX - 1) ? last_pos : NPIX - 1;
        send_bytes(n, last_pos);
        chk("ferr_pos", err_at, exp_pos);
        repeat (2) tick();
        chk("ferr_count", ferr_seen - f0, 1);
        chk("no_start", start_seen - s0, 0);
        chk("load_ready", s_ready, 1);
        chk("load_busy", busy, 0);
    endtask

    // One good frame. timeout: stub never answers. bp: extra cycles of res_ready=0.
    // keep: leave acc_done high afterwards so the next frame starts with a stale done.
    task automatic run_frame(input bit timeout, input int delay, input int bp, input bit keep);
        int         s0 = start_seen;
        int         cnt = 0;
        logic [3:0] pred = 4'($urandom_range(0, 9));
        logic [3:0] exp_dig;
        logic       stable = 1'b1;
        logic       nocap = 1'b1;
        send_bytes(NPIX, NPIX - 1);
        chk("acc_start_hi", acc_start, 1);
        chk("s_ready_start", s_ready, 0);
        chk("busy_start", busy, 1);
        chk("img_data", img_data == exp_vec, 1);
        tick();
        chk("acc_start_lo", acc_start, 0);
        if (timeout) begin
            while (!res_valid && cnt < 4 * TMO) begin
                tick();
                cnt++;
            end
            chk("tmo_latency", cnt, TMO);
            exp_dig = 4'hF;
            chk("tmo_err", res_err, 1);
        end else begin
            if (acc_done) begin
                repeat (10) begin
                    tick();
                    if (res_valid) nocap = 1'b0;
                end
                chk("stale_nocap", nocap, 1);
                acc_done = 1'b0;
                tick();
            end
            repeat (delay) tick();
            acc_done = 1'b1;
            acc_pred = pred;
            tick();
            chk("capt_not_valid", res_valid, 0);
            tick();
            chk("res_valid", res_valid, 1);
            exp_dig = pred;
            chk("res_err", res_err, 0);
        end
        chk("res_digit", res_digit, exp_dig);
        exp_cnt++;
        chk("frame_cnt", frame_cnt, exp_cnt);
        if (!keep) acc_done = 1'b0;
        acc_pred = 4'($urandom);
        repeat (bp) begin
            tick();
            if (!res_valid || res_digit != exp_dig || s_ready) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("img_held", img_data == exp_vec, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_drop", res_valid, 0);
        chk("ready_back", s_ready, 1);
        chk("busy_idle", busy, 0);
        chk("one_start", start_seen - s0, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_digit", res_digit, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_img", img_data == '0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk_reset_vals();
        rst = 1'b1;
        chk("ready_before_edge", s_ready, 0);
        tick();
        chk("ready_after_edge", s_ready, 1);

        run_frame(0, 5, 0, 0);
        bad_frame(100, 99);
        run_frame(0, $urandom_range(0, 20), 0, 0);
        bad_frame(790, 789);
        run_frame(0, $urandom_range(0, 20), 20, 1);
        run_frame(0, $urandom_range(0, 20), 3, 0);
        run_frame(1, 0, 20, 0);
        for (int f = 0; f < 2; f++)
            run_frame(0, $urandom_range(0, 20), $urandom_range(0, 4), 0);

        // Reset in the middle of WAIT
        send_bytes(NPIX, NPIX - 1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) tick();
        rst = 1'b1;
        chk("rel_ready_lo", s_ready, 0);
        tick();
        chk("rel_ready_hi", s_ready, 1);
        exp_cnt = 16'd0;
        run_frame(0, $urandom_range(0, 20), 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
